// File: rtl/rv_pkg.sv
// Register-file constants shared by the decode-stage scoreboard and its bench.
// regOneHot turns a register index into a one-hot vector, never selecting x0.
package rv_pkg;

  localparam int REG_ADDR_W    = 5;
  localparam int NUM_ARCH_REGS = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  function automatic logic [NUM_ARCH_REGS-1:0] regOneHot(input logic [REG_ADDR_W-1:0] r,
                                                         input logic en);
    logic [NUM_ARCH_REGS-1:0] v;
    v    = '0;
    v[r] = en;
    v[0] = 1'b0;
    return v;
  endfunction

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback/kill bundle between the pipeline (master) and the scoreboard (slave).
interface regfile_scoreboard_if
  import rv_pkg::*;
#(
  parameter int STAT_W = 32
) ();

  logic                     issue_valid;
  logic [REG_ADDR_W-1:0]    issue_rs1;
  logic [REG_ADDR_W-1:0]    issue_rs2;
  logic                     issue_use_rs1;
  logic                     issue_use_rs2;
  logic                     issue_wr_rd;
  logic [REG_ADDR_W-1:0]    issue_rd;
  logic                     issue_stall;
  logic                     wb_valid;
  logic [REG_ADDR_W-1:0]    wb_rd;
  logic                     kill_valid;
  logic [REG_ADDR_W-1:0]    kill_rd;
  logic [NUM_ARCH_REGS-1:0] busy_mask;
  logic                     err_underflow;
  logic [STAT_W-1:0]        stall_cycles;

  modport master (
    output issue_valid, issue_rs1, issue_rs2, issue_use_rs1, issue_use_rs2,
           issue_wr_rd, issue_rd, wb_valid, wb_rd, kill_valid, kill_rd,
    input  issue_stall, busy_mask, err_underflow, stall_cycles
  );

  modport slave (
    input  issue_valid, issue_rs1, issue_rs2, issue_use_rs1, issue_use_rs2,
           issue_wr_rd, issue_rd, wb_valid, wb_rd, kill_valid, kill_rd,
    output issue_stall, busy_mask, err_underflow, stall_cycles
  );

endinterface

// File: rtl/regfile_scoreboard_counter.sv
// One in-flight write counter: +inc, -dec_wb, -dec_kill applied together at the edge.
// Excess decrements clamp at zero and pulse underflow for the sticky error.
module sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec_wb,
  input  logic             dec_kill,
  output logic [CNT_W-1:0] count,
  output logic             underflow
);

  localparam logic [CNT_W:0] CNT_MAX = (CNT_W+1)'((1 << CNT_W) - 1);

  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W:0]   total, decSum, diff;

  always_comb begin
    total     = (CNT_W+1)'(count_q) + (CNT_W+1)'(inc);
    decSum    = (CNT_W+1)'(dec_wb) + (CNT_W+1)'(dec_kill);
    diff      = total - decSum;
    underflow = decSum > total;
    count_d   = count_q;
    if (underflow) begin
      count_d = '0;
    end else if (diff > CNT_MAX) begin
      count_d = CNT_MAX[CNT_W-1:0];
    end else begin
      count_d = diff[CNT_W-1:0];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Decode-stage scoreboard: per-register pending-write counters for x1..x31, RAW and
// rd-saturation stall, busy mask, sticky underflow flag and a wrapping stall counter.
module regfile_scoreboard
  import rv_pkg::*;
#(
  parameter int CNT_W     = 2,
  parameter int WB_BYPASS = 1,
  parameter int STAT_W    = 32
) (
  input logic                 clock,
  input logic                 reset,
  regfile_scoreboard_if.slave sb
);

  localparam logic [CNT_W-1:0] CNT_SAT = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0]         cnt [NUM_ARCH_REGS];
  logic [NUM_ARCH_REGS-1:0] incVec, wbVec, killVec, uflVec, busyVec, readBusy;
  logic                     rdSat, issueStall, accept;
  logic                     err_q, err_d;
  logic [STAT_W-1:0]        stallCycles_q, stallCycles_d;

  assign cnt[0]    = '0;
  assign uflVec[0] = 1'b0;

  // A retiring write that empties its counter is visible to this cycle's read when bypassing.
  always_comb begin
    busyVec  = '0;
    readBusy = '0;
    for (int r = 0; r < NUM_ARCH_REGS; r++) begin
      busyVec[r]  = cnt[r] != '0;
      readBusy[r] = busyVec[r];
      if (WB_BYPASS != 0 && wbVec[r] && !killVec[r] && cnt[r] == CNT_ONE) begin
        readBusy[r] = 1'b0;
      end
    end
  end

  always_comb begin
    rdSat      = sb.issue_wr_rd && (sb.issue_rd != REG_ZERO) && (cnt[sb.issue_rd] == CNT_SAT);
    issueStall = sb.issue_valid && ((sb.issue_use_rs1 && readBusy[sb.issue_rs1]) ||
                                    (sb.issue_use_rs2 && readBusy[sb.issue_rs2]) ||
                                    rdSat);
    accept     = sb.issue_valid && !issueStall;
    incVec     = regOneHot(sb.issue_rd, accept && sb.issue_wr_rd);
    wbVec      = regOneHot(sb.wb_rd, sb.wb_valid);
    killVec    = regOneHot(sb.kill_rd, sb.kill_valid);
  end

  for (genvar g = 1; g < NUM_ARCH_REGS; g++) begin : g_cnt
    sb_counter #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .clock    (clock),
      .reset    (reset),
      .inc      (incVec[g]),
      .dec_wb   (wbVec[g]),
      .dec_kill (killVec[g]),
      .count    (cnt[g]),
      .underflow(uflVec[g])
    );
  end

  always_comb begin
    err_d         = err_q || (|uflVec);
    stallCycles_d = stallCycles_q + STAT_W'(sb.issue_valid && issueStall);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_q         <= 1'b0;
      stallCycles_q <= '0;
    end else begin
      err_q         <= err_d;
      stallCycles_q <= stallCycles_d;
    end
  end

  assign sb.issue_stall   = issueStall;
  assign sb.busy_mask     = busyVec;
  assign sb.err_underflow = err_q;
  assign sb.stall_cycles  = stallCycles_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: each vector queues its expected outputs and a
// negedge monitor pops and compares them against the DUT.
module tb_regfile_scoreboard;
  import rv_pkg::*;

  typedef struct {
    string       name;
    logic        stall;
    logic [31:0] busy;
    logic        err;
    logic [31:0] stalls;
  } expRec_t;

  logic clock;
  logic reset;
  int   testsRun   = 0;
  int   testsFailed = 0;
  int   stallModel = 0;
  expRec_t sbQ[$];

  regfile_scoreboard_if #(.STAT_W(32)) sbIf ();

  regfile_scoreboard #(
    .CNT_W    (2),
    .WB_BYPASS(1),
    .STAT_W   (32)
  ) dut (
    .clock(clock),
    .reset(reset),
    .sb   (sbIf.slave)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic checkOutput(input string name, input string field,
                             input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s.%s: got %0h expected %0h", name, field, actual, expected);
    end
  endtask

  task automatic driveInputs(input logic iv, input logic u1, input logic [4:0] rs1,
                             input logic u2, input logic [4:0] rs2,
                             input logic wr, input logic [4:0] rd,
                             input logic wbv, input logic [4:0] wbrd,
                             input logic kv, input logic [4:0] krd);
    sbIf.issue_valid   = iv;
    sbIf.issue_use_rs1 = u1;
    sbIf.issue_rs1     = rs1;
    sbIf.issue_use_rs2 = u2;
    sbIf.issue_rs2     = rs2;
    sbIf.issue_wr_rd   = wr;
    sbIf.issue_rd      = rd;
    sbIf.wb_valid      = wbv;
    sbIf.wb_rd         = wbrd;
    sbIf.kill_valid    = kv;
    sbIf.kill_rd       = krd;
  endtask

  task automatic applyStimulus(input string name, input logic iv,
                               input logic u1, input logic [4:0] rs1,
                               input logic u2, input logic [4:0] rs2,
                               input logic wr, input logic [4:0] rd,
                               input logic wbv, input logic [4:0] wbrd,
                               input logic kv, input logic [4:0] krd,
                               input logic eStall, input logic [31:0] eBusy, input logic eErr);
    expRec_t rec;
    @(posedge clock);
    #1;
    driveInputs(iv, u1, rs1, u2, rs2, wr, rd, wbv, wbrd, kv, krd);
    rec.name   = name;
    rec.stall  = eStall;
    rec.busy   = eBusy;
    rec.err    = eErr;
    rec.stalls = 32'(stallModel);
    sbQ.push_back(rec);
    if (iv && eStall) stallModel++;
  endtask

  always @(negedge clock) begin
    expRec_t e;
    if (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      checkOutput(e.name, "issue_stall", {31'b0, sbIf.issue_stall}, {31'b0, e.stall});
      checkOutput(e.name, "busy_mask", sbIf.busy_mask, e.busy);
      checkOutput(e.name, "err_underflow", {31'b0, sbIf.err_underflow}, {31'b0, e.err});
      checkOutput(e.name, "stall_cycles", sbIf.stall_cycles, e.stalls);
    end
  end

  initial begin
    reset = 1'b1;
    driveInputs(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clock);
    #2 reset = 1'b0;

    //            name              iv u1 rs1 u2 rs2 wr rd  wb wbrd kv krd  stall busy          err
    applyStimulus("idle",           0, 0, 0,  0, 0,  0, 0,  0, 0,   0, 0,   0, 32'h0,         0);
    applyStimulus("x0_issue",       1, 0, 0,  0, 0,  1, 0,  0, 0,   0, 0,   0, 32'h0,         0);
    applyStimulus("x0_read",        1, 1, 0,  1, 0,  0, 0,  1, 0,   1, 0,   0, 32'h0,         0);
    applyStimulus("raw_issue",      1, 0, 0,  0, 0,  1, 5,  0, 0,   0, 0,   0, 32'h0,         0);
    applyStimulus("raw_stall_a",    1, 1, 5,  0, 0,  0, 0,  0, 0,   0, 0,   1, 32'h20,        0);
    applyStimulus("raw_stall_b",    1, 1, 5,  0, 0,  0, 0,  0, 0,   0, 0,   1, 32'h20,        0);
    applyStimulus("raw_wb_bypass",  1, 1, 5,  0, 0,  0, 0,  1, 5,   0, 0,   0, 32'h20,        0);
    applyStimulus("raw_cleared",    0, 0, 0,  0, 0,  0, 0,  0, 0,   0, 0,   0, 32'h0,         0);
    applyStimulus("sat_issue1",     1, 0, 0,  0, 0,  1, 7,  0, 0,   0, 0,   0, 32'h0,         0);
    applyStimulus("sat_issue2",     1, 0, 0,  0, 0,  1, 7,  0, 0,   0, 0,   0, 32'h80,        0);
    applyStimulus("sat_issue3",     1, 0, 0,  0, 0,  1, 7,  0, 0,   0, 0,   0, 32'h80,        0);
    applyStimulus("sat_stall",      1, 0, 0,  0, 0,  1, 7,  0, 0,   0, 0,   1, 32'h80,        0);
    applyStimulus("sat_stall_wb",   1, 0, 0,  0, 0,  1, 7,  1, 7,   0, 0,   1, 32'h80,        0);
    applyStimulus("sat_refill",     1, 0, 0,  0, 0,  1, 7,  0, 0,   0, 0,   0, 32'h80,        0);
    applyStimulus("sat_full_again", 1, 0, 0,  0, 0,  1, 7,  0, 0,   0, 0,   1, 32'h80,        0);
    applyStimulus("drain_a",        0, 0, 0,  0, 0,  0, 0,  1, 7,   0, 0,   0, 32'h80,        0);
    applyStimulus("drain_b",        0, 0, 0,  0, 0,  0, 0,  1, 7,   0, 0,   0, 32'h80,        0);
    applyStimulus("drain_bypass",   1, 0, 0,  1, 7,  0, 0,  1, 7,   0, 0,   0, 32'h80,        0);
    applyStimulus("drain_done",     0, 0, 0,  0, 0,  0, 0,  0, 0,   0, 0,   0, 32'h0,         0);
    applyStimulus("sim_issue",      1, 0, 0,  0, 0,  1, 9,  0, 0,   0, 0,   0, 32'h0,         0);
    applyStimulus("sim_issue_wb",   1, 0, 0,  0, 0,  1, 9,  1, 9,   0, 0,   0, 32'h200,       0);
    applyStimulus("sim_issue2",     1, 0, 0,  0, 0,  1, 9,  0, 0,   0, 0,   0, 32'h200,       0);
    applyStimulus("sim_wb_kill",    1, 1, 9,  0, 0,  0, 0,  1, 9,   1, 9,   1, 32'h200,       0);
    applyStimulus("sim_done",       0, 0, 0,  0, 0,  0, 0,  0, 0,   0, 0,   0, 32'h0,         0);
    applyStimulus("ufl_wb",         0, 0, 0,  0, 0,  0, 0,  1, 12,  0, 0,   0, 32'h0,         0);
    applyStimulus("ufl_sticky",     0, 0, 0,  0, 0,  0, 0,  0, 0,   0, 0,   0, 32'h0,         1);
    applyStimulus("ufl_read",       1, 1, 12, 0, 0,  0, 0,  0, 0,   0, 0,   0, 32'h0,         1);
    applyStimulus("kill_issue",     1, 0, 0,  0, 0,  1, 3,  0, 0,   0, 0,   0, 32'h0,         1);
    applyStimulus("kill_only",      0, 0, 0,  0, 0,  0, 0,  0, 0,   1, 3,   0, 32'h8,         1);
    applyStimulus("kill_done",      0, 0, 0,  0, 0,  0, 0,  0, 0,   0, 0,   0, 32'h0,         1);
    applyStimulus("rst_issue",      1, 0, 0,  0, 0,  1, 20, 0, 0,   0, 0,   0, 32'h0,         1);
    applyStimulus("rst_stall",      1, 1, 20, 0, 0,  0, 0,  0, 0,   0, 0,   1, 32'h0010_0000, 1);

    // Asynchronous reset between edges must clear everything immediately.
    #6 reset = 1'b1;
    #1;
    checkOutput("mid_reset", "busy_mask", sbIf.busy_mask, 32'h0);
    checkOutput("mid_reset", "err_underflow", {31'b0, sbIf.err_underflow}, 32'h0);
    checkOutput("mid_reset", "stall_cycles", sbIf.stall_cycles, 32'h0);
    checkOutput("mid_reset", "issue_stall", {31'b0, sbIf.issue_stall}, 32'h0);
    stallModel = 0;
    driveInputs(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clock);
    #2 reset = 1'b0;

    applyStimulus("post_reset",     1, 1, 20, 0, 0,  0, 0,  0, 0,   0, 0,   0, 32'h0,         0);
    applyStimulus("post_idle",      0, 0, 0,  0, 0,  0, 0,  0, 0,   0, 0,   0, 32'h0,         0);

    for (int i = 0; i < 10 && sbQ.size() != 0; i++) @(negedge clock);
    #1;
    if (sbQ.size() != 0) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL monitor_drain: got %0d pending expected 0", sbQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
